// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg.sv
// Shared types and limits for the bufz tristate-net arbiter.
// Holds the FSM state encoding, counter widths and the legal parameter ranges.
package gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg;

    localparam int STATE_W = 2;
    localparam int HOLD_W  = 8;
    localparam int TURN_W  = 3;

    localparam int N_REQ_MIN      = 2;
    localparam int N_REQ_MAX      = 16;
    localparam int TURNAROUND_MIN = 1;
    localparam int TURNAROUND_MAX = 7;
    localparam int MAX_HOLD_MIN   = 1;
    localparam int MAX_HOLD_MAX   = 255;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from base, wrapping at N_REQ.
module gf180mcu_fd_sc_mcu9t5v0__bufz_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    base,
    output logic             valid,
    output logic [IW-1:0]    index
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IW'((32'(base) + i) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_arb.sv
// Arbiter for N_REQ bufz drivers sharing one tristate net: one-hot enables,
// forced rotation after MAX_HOLD cycles, TURNAROUND dead cycles between owners.
module gf180mcu_fd_sc_mcu9t5v0__bufz_arb
    import gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                     CLK,
    input  logic                     RN,
    input  logic [N_REQ-1:0]         REQ,
    output logic [N_REQ-1:0]         EN,
    output logic [N_REQ-1:0]         GNT,
    output logic [$clog2(N_REQ)-1:0] OWNER,
    output logic                     BUSY
);

    localparam int OW = $clog2(N_REQ);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX ||
        TURNAROUND < TURNAROUND_MIN || TURNAROUND > TURNAROUND_MAX ||
        MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_param_check
        $error("bufz_arb: parameter out of range");
    end

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     base_q, base_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [N_REQ-1:0]  en_q, en_d;
    logic              busy_q, busy_d;

    logic              pick_valid;
    logic [OW-1:0]     pick_idx;
    logic [N_REQ-1:0]  owner_mask;
    logic              owner_drop, hold_expired, arbitrate;

    gf180mcu_fd_sc_mcu9t5v0__bufz_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (OW)
    ) u_rr_pick (
        .req   (REQ),
        .base  (base_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        owner_drop          = !REQ[owner_q];
        hold_expired        = (hold_q == HOLD_W'(MAX_HOLD)) && |(REQ & ~owner_mask);

        state_d   = state_q;
        owner_d   = owner_q;
        base_d    = base_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        arbitrate = 1'b0;

        unique case (state_q)
            IDLE: arbitrate = 1'b1;
            GRANT: begin
                // A simultaneous drop and expiry is one release, hence the single branch.
                if (owner_drop || hold_expired) begin
                    state_d = TURN;
                    turn_d  = TURN_W'(TURNAROUND - 1);
                    hold_d  = '0;
                end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            TURN: begin
                if (turn_q == '0) arbitrate = 1'b1;
                else              turn_d    = turn_q - TURN_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (arbitrate) begin
            turn_d = '0;
            if (pick_valid) begin
                state_d = GRANT;
                owner_d = pick_idx;
                base_d  = (pick_idx == OW'(N_REQ - 1)) ? '0 : pick_idx + OW'(1);
                hold_d  = HOLD_W'(1);
            end else begin
                state_d = IDLE;
            end
        end

        en_d = '0;
        if (state_d == GRANT) en_d[owner_d] = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= IDLE;
            owner_q <= '0;
            base_q  <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign EN    = en_q;
    assign GNT   = en_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bufz_arb.sv
// Bench for the bufz arbiter: two instances (TURNAROUND 1 and 2, MAX_HOLD 4)
// share stimulus; a behavioural model feeds a scoreboard, tasks add directed checks.
module tb_gf180mcu_fd_sc_mcu9t5v0__bufz_arb;

    localparam int MH = 4;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic [3:0] REQ = 4'b0000;
    logic [3:0] EN1, GNT1, EN2, GNT2;
    logic [1:0] OWNER1, OWNER2;
    logic       BUSY1, BUSY2;

    int errors = 0;
    int checks = 0;

    gf180mcu_fd_sc_mcu9t5v0__bufz_arb #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(MH)) u_dut1 (
        .CLK(CLK), .RN(RN), .REQ(REQ), .EN(EN1), .GNT(GNT1), .OWNER(OWNER1), .BUSY(BUSY1)
    );
    gf180mcu_fd_sc_mcu9t5v0__bufz_arb #(.N_REQ(4), .TURNAROUND(2), .MAX_HOLD(MH)) u_dut2 (
        .CLK(CLK), .RN(RN), .REQ(REQ), .EN(EN2), .GNT(GNT2), .OWNER(OWNER2), .BUSY(BUSY2)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: st 0=idle 1=grant 2=turn
    typedef struct { int st; int owner; int ptr; int hold; int turn; } mstate_t;
    mstate_t m[2];
    int ta[2] = '{1, 2};

    typedef struct packed {
        logic [3:0] en1; logic [1:0] ow1; logic b1;
        logic [3:0] en2; logic [1:0] ow2; logic b2;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    function automatic int rr_first(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++) begin
            int c = (from + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge(input int d, input logic rn, input logic [3:0] r);
        int w;
        if (!rn) begin
            m[d] = '{st: 0, owner: 0, ptr: 0, hold: 0, turn: 0};
            return;
        end
        if (m[d].st == 1) begin
            if (!r[m[d].owner] || (m[d].hold == MH && (r & ~(4'b0001 << m[d].owner)) != 4'b0000)) begin
                m[d].st   = 2;
                m[d].turn = ta[d] - 1;
            end else if (m[d].hold < MH) begin
                m[d].hold++;
            end
            return;
        end
        if (m[d].st == 2 && m[d].turn > 0) begin
            m[d].turn--;
            return;
        end
        w = rr_first(r, m[d].ptr);
        if (w < 0) begin
            m[d].st = 0;
        end else begin
            m[d].st    = 1;
            m[d].owner = w;
            m[d].ptr   = (w + 1) % 4;
            m[d].hold  = 1;
        end
    endtask

    function automatic logic [3:0] m_en(input int d);
        return (m[d].st == 1) ? 4'(1 << m[d].owner) : 4'b0000;
    endfunction

    task automatic step(input logic rn, input logic [3:0] r);
        exp_t e;
        RN  = rn;
        REQ = r;
        model_edge(0, rn, r);
        model_edge(1, rn, r);
        e.en1 = m_en(0); e.ow1 = 2'(m[0].owner); e.b1 = (m[0].st != 0);
        e.en2 = m_en(1); e.ow2 = 2'(m[1].owner); e.b2 = (m[1].st != 0);
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    always @(posedge CLK) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++; if (EN1 !== mon_e.en1)    begin errors++; $display("FAIL sb_en1 got=%b exp=%b t=%0t", EN1, mon_e.en1, $time); end
            checks++; if (GNT1 !== mon_e.en1)   begin errors++; $display("FAIL sb_gnt1 got=%b exp=%b t=%0t", GNT1, mon_e.en1, $time); end
            checks++; if (OWNER1 !== mon_e.ow1) begin errors++; $display("FAIL sb_owner1 got=%0d exp=%0d t=%0t", OWNER1, mon_e.ow1, $time); end
            checks++; if (BUSY1 !== mon_e.b1)   begin errors++; $display("FAIL sb_busy1 got=%b exp=%b t=%0t", BUSY1, mon_e.b1, $time); end
            checks++; if (EN2 !== mon_e.en2)    begin errors++; $display("FAIL sb_en2 got=%b exp=%b t=%0t", EN2, mon_e.en2, $time); end
            checks++; if (GNT2 !== mon_e.en2)   begin errors++; $display("FAIL sb_gnt2 got=%b exp=%b t=%0t", GNT2, mon_e.en2, $time); end
            checks++; if (OWNER2 !== mon_e.ow2) begin errors++; $display("FAIL sb_owner2 got=%0d exp=%0d t=%0t", OWNER2, mon_e.ow2, $time); end
            checks++; if (BUSY2 !== mon_e.b2)   begin errors++; $display("FAIL sb_busy2 got=%b exp=%b t=%0t", BUSY2, mon_e.b2, $time); end
        end
    end

    task automatic test_reset();
        step(1'b0, 4'b1111);
        step(1'b0, 4'b0000);
        checks++; if (EN1 !== 4'b0000)  begin errors++; $display("FAIL reset_en1 got=%b exp=0000", EN1); end
        checks++; if (OWNER1 !== 2'd0)  begin errors++; $display("FAIL reset_owner1 got=%0d exp=0", OWNER1); end
        checks++; if (BUSY1 !== 1'b0)   begin errors++; $display("FAIL reset_busy1 got=%b exp=0", BUSY1); end
        step(1'b1, 4'b0000);
        checks++; if (EN2 !== 4'b0000)  begin errors++; $display("FAIL reset_first_high_en2 got=%b exp=0000", EN2); end
    endtask

    task automatic test_basic();
        step(1'b1, 4'b0001);
        checks++; if (EN1 !== 4'b0001)  begin errors++; $display("FAIL basic_en1 got=%b exp=0001", EN1); end
        checks++; if (OWNER1 !== 2'd0)  begin errors++; $display("FAIL basic_owner1 got=%0d exp=0", OWNER1); end
        checks++; if (BUSY1 !== 1'b1)   begin errors++; $display("FAIL basic_busy1 got=%b exp=1", BUSY1); end
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0000);
        checks++; if (EN1 !== 4'b0000)  begin errors++; $display("FAIL basic_release_en1 got=%b exp=0000", EN1); end
        checks++; if (BUSY1 !== 1'b1)   begin errors++; $display("FAIL basic_turn_busy1 got=%b exp=1", BUSY1); end
        step(1'b1, 4'b0000);
        checks++; if (BUSY1 !== 1'b0)   begin errors++; $display("FAIL basic_idle_busy1 got=%b exp=0", BUSY1); end
        checks++; if (BUSY2 !== 1'b1)   begin errors++; $display("FAIL basic_turn2_busy2 got=%b exp=1", BUSY2); end
        step(1'b1, 4'b0000);
        checks++; if (BUSY2 !== 1'b0)   begin errors++; $display("FAIL basic_idle_busy2 got=%b exp=0", BUSY2); end
    endtask

    task automatic test_rotation();
        logic [3:0] e1, e2;
        step(1'b0, 4'b0000);
        step(1'b1, 4'b0000);
        for (int t = 1; t <= 30; t++) begin
            step(1'b1, 4'b1111);
            e1 = (((t - 1) % 5) < 4) ? 4'(1 << (((t - 1) / 5) % 4)) : 4'b0000;
            e2 = (((t - 1) % 6) < 4) ? 4'(1 << (((t - 1) / 6) % 4)) : 4'b0000;
            checks++; if (EN1 !== e1) begin errors++; $display("FAIL rot_en1 t=%0d got=%b exp=%b", t, EN1, e1); end
            checks++; if (EN2 !== e2) begin errors++; $display("FAIL rot_en2 t=%0d got=%b exp=%b", t, EN2, e2); end
            checks++; if ($countones(EN2) > 1) begin errors++; $display("FAIL rot_onehot2 t=%0d got=%b exp=at most one bit", t, EN2); end
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 4'b0000);
        step(1'b1, 4'b1000);
        checks++; if (OWNER1 !== 2'd3)  begin errors++; $display("FAIL wrap_owner1 got=%0d exp=3", OWNER1); end
        repeat (3) step(1'b1, 4'b1001);
        checks++; if (EN1 !== 4'b1000)  begin errors++; $display("FAIL wrap_hold_en1 got=%b exp=1000", EN1); end
        step(1'b1, 4'b1001);
        checks++; if (EN1 !== 4'b0000)  begin errors++; $display("FAIL wrap_turn_en1 got=%b exp=0000", EN1); end
        step(1'b1, 4'b1001);
        checks++; if (EN1 !== 4'b0001)  begin errors++; $display("FAIL wrap_en1 got=%b exp=0001", EN1); end
        checks++; if (OWNER1 !== 2'd0)  begin errors++; $display("FAIL wrap_owner1_new got=%0d exp=0", OWNER1); end
        checks++; if (EN2 !== 4'b0000)  begin errors++; $display("FAIL wrap_turn_en2 got=%b exp=0000", EN2); end
        step(1'b1, 4'b1001);
        checks++; if (EN2 !== 4'b0001)  begin errors++; $display("FAIL wrap_en2 got=%b exp=0001", EN2); end
    endtask

    task automatic test_hold_alone();
        step(1'b0, 4'b0000);
        for (int t = 1; t <= 20; t++) begin
            step(1'b1, 4'b0100);
            checks++; if (EN1 !== 4'b0100) begin errors++; $display("FAIL alone_en1 t=%0d got=%b exp=0100", t, EN1); end
            checks++; if (EN2 !== 4'b0100) begin errors++; $display("FAIL alone_en2 t=%0d got=%b exp=0100", t, EN2); end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 4'b0000);
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0010);
        checks++; if (EN1 !== 4'b0010)  begin errors++; $display("FAIL rmid_pre_en1 got=%b exp=0010", EN1); end
        step(1'b0, 4'b0010);
        checks++; if (EN1 !== 4'b0000)  begin errors++; $display("FAIL rmid_en1 got=%b exp=0000", EN1); end
        checks++; if (OWNER1 !== 2'd0)  begin errors++; $display("FAIL rmid_owner1 got=%0d exp=0", OWNER1); end
        step(1'b1, 4'b0010);
        checks++; if (EN1 !== 4'b0010)  begin errors++; $display("FAIL rmid_regrant_en1 got=%b exp=0010", EN1); end
    endtask

    task automatic test_release_expiry();
        step(1'b0, 4'b0000);
        repeat (4) step(1'b1, 4'b0011);
        checks++; if (EN1 !== 4'b0001)  begin errors++; $display("FAIL relexp_hold_en1 got=%b exp=0001", EN1); end
        step(1'b1, 4'b0010);
        checks++; if (EN1 !== 4'b0000)  begin errors++; $display("FAIL relexp_turn_en1 got=%b exp=0000", EN1); end
        checks++; if (EN2 !== 4'b0000)  begin errors++; $display("FAIL relexp_turn_en2 got=%b exp=0000", EN2); end
        step(1'b1, 4'b0010);
        checks++; if (EN1 !== 4'b0010)  begin errors++; $display("FAIL relexp_next_en1 got=%b exp=0010", EN1); end
        checks++; if (EN2 !== 4'b0000)  begin errors++; $display("FAIL relexp_turn2_en2 got=%b exp=0000", EN2); end
        step(1'b1, 4'b0010);
        checks++; if (EN2 !== 4'b0010)  begin errors++; $display("FAIL relexp_next_en2 got=%b exp=0010", EN2); end
    endtask

    task automatic test_random();
        step(1'b0, 4'b0000);
        for (int t = 0; t < 200; t++) begin
            step(($urandom_range(0, 29) != 0), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLK);
        test_reset();
        test_basic();
        test_rotation();
        test_wrap();
        test_hold_alone();
        test_reset_mid();
        test_release_expiry();
        test_random();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__bufz_arb.md
GF180MCU_FD_SC_MCU9T5V0__BUFZ_ARB -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__bufz_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters / bufz drivers on one shared tristate net, range 2..16.
REQ-002 Parameter TURNAROUND, default 1: dead cycles with all enables low between owners, range 1..7.
REQ-003 Parameter MAX_HOLD, default 16: grant cycles before forced rotation when another requester is pending, range 1..255.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RN  input  1  reset, synchronous, active-low.
REQ-006 REQ  input  N_REQ  per-requester bus request, level-sensitive, held until served.
REQ-007 EN  output  N_REQ  per-driver tristate enable to the bufz EN pins; zero-hot or one-hot.
REQ-008 GNT  output  N_REQ  grant to requester logic; identical to EN.
REQ-009 OWNER  output  clog2(N_REQ)  index of current owner; holds the last owner when no grant is active.
REQ-010 BUSY  output  1  high in GRANT and TURN states.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and TURN.
REQ-012 All outputs SHALL be registered; EN, GNT and BUSY SHALL be driven from state and owner registers only.
REQ-013 At most one EN bit SHALL be high in any cycle; EN SHALL be all-zero in IDLE and TURN.
REQ-014 IDLE: when any REQ bit is sampled high at edge k, the FSM SHALL move to GRANT with EN one-hot at the winner after edge k, giving 1-cycle latency.
REQ-015 Winner selection SHALL be round-robin: the first set REQ bit searching upward from (last OWNER + 1) mod N_REQ with wrap-around; after reset the search starts at index 0.
REQ-016 GRANT: the hold counter SHALL start at 1 on entry and increment each cycle, saturating at MAX_HOLD.
REQ-017 GRANT SHALL exit to TURN when REQ[OWNER] is sampled low.
REQ-018 GRANT SHALL also exit to TURN when the hold counter equals MAX_HOLD and any other REQ bit is high.
REQ-019 If the hold counter equals MAX_HOLD and no other requester is pending, the FSM SHALL remain in GRANT with the counter saturated.
REQ-020 If owner release and hold expiry occur in the same cycle, the FSM SHALL treat the event as a single release to TURN.
REQ-021 TURN SHALL last exactly TURNAROUND cycles; a turn counter loads TURNAROUND-1 on entry and decrements to 0.
REQ-022 When TURN ends, the FSM SHALL arbitrate as in IDLE in the same cycle: GRANT if any REQ is high, else IDLE.
REQ-023 A requester that re-requests as the only pending requester SHALL be re-granted after the TURN period.
REQ-024 OWNER SHALL update only on entry to GRANT.
REQ-025 REQ changes during TURN SHALL have no effect until the final TURN cycle's arbitration.

Reset
REQ-026 When RN is sampled low, state SHALL become IDLE, EN=GNT=0, BUSY=0, OWNER=0, both counters 0 and the round-robin pointer 0, overriding any in-progress grant at that edge.
REQ-027 EN SHALL be all-zero from the first reset edge and SHALL remain zero through the first edge with RN high.

Structure
REQ-028 A shared package gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg SHALL hold the state enum (IDLE, GRANT, TURN), the encoding widths and the parameter range limits.
REQ-029 Round-robin selection SHALL live in one combinational sub-module gf180mcu_fd_sc_mcu9t5v0__bufz_arb_rr_pick with inputs req and base index and outputs valid and index.
REQ-030 The top level SHALL contain only the FSM, the counters and the output registers.

Verification
REQ-031 Reset then REQ=0001 at edge 1 -> EN=0001, OWNER=0 and BUSY=1 after edge 1; REQ=0000 at edge 4 -> EN=0000 after edge 4, one TURN cycle, then IDLE with BUSY=0.
REQ-032 REQ=1111 held, MAX_HOLD=4, TURNAROUND=2 -> grant order 0,1,2,3,0; each grant lasts 4 cycles; 2 all-zero EN cycles between grants; EN never multi-hot.
REQ-033 OWNER=3 and REQ=1001 at release -> after TURN, EN=0001 (wrap-around).
REQ-034 Only REQ[2] held beyond MAX_HOLD=4 -> EN=0100 continuously for 20 cycles with no TURN inserted.
REQ-035 RN low during GRANT with EN=0010 -> EN=0000 and OWNER=0 after that edge; with REQ=0010 still high after RN returns high, EN=0010 one cycle later.
REQ-036 Owner drops REQ in the same cycle its hold counter hits MAX_HOLD with others pending -> exactly one TURN period of TURNAROUND cycles, then the next round-robin owner is granted.
